// File: rtl/can_param_loader.sv
// Round-robin arbiter that serializes one requester's CAN filter parameter set
// (mask, code, SJW) onto the byte-wide registry load port, then holds a settle gap.
module can_param_loader #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [11*NUM_REQ-1:0]  mask_in,
  input  logic [11*NUM_REQ-1:0]  code_in,
  input  logic [2*NUM_REQ-1:0]   sjw_in,
  output logic                   param_id,
  output logic [7:0]             param_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy
);

  // state | meaning
  // IDLE  | waiting for any req; arbitration happens here
  // SEND0 | param_id strobe, mask[7:0] on the port
  // SEND1 | {code[4:0], mask[10:8]}
  // SEND2 | {sjw, code[10:5]}
  // GAP   | settle time; done pulses in the first cycle
  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, GAP} state_t;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state;
  logic [IW-1:0]      last_served;
  logic [GW-1:0]      gap_cnt;
  logic [2:0]         mask_hi_sh;
  logic [10:0]        code_sh;
  logic [1:0]         sjw_sh;
  logic [NUM_REQ-1:0] sel_oh;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] win_oh;
  logic [10:0]        mask_sel;
  logic [10:0]        code_sel;
  logic [1:0]         sjw_sel;

  // Search starts just after the last served requester and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(last_served) + 1 + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    mask_sel = '0;
    code_sel = '0;
    sjw_sel  = '0;
    win_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        mask_sel  = mask_in[11*i +: 11];
        code_sel  = code_in[11*i +: 11];
        sjw_sel   = sjw_in[2*i +: 2];
        win_oh[i] = 1'b1;
      end
    end
  end

  // Byte 0 leaves on the same edge the set is captured, so only the
  // remaining mask bits need a shadow copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= IW'(NUM_REQ - 1);
      gap_cnt     <= '0;
      mask_hi_sh  <= '0;
      code_sh     <= '0;
      sjw_sh      <= '0;
      sel_oh      <= '0;
      param_id    <= 1'b0;
      param_data  <= '0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= SEND0;
            last_served <= win_idx;
            mask_hi_sh  <= mask_sel[10:8];
            code_sh     <= code_sel;
            sjw_sh      <= sjw_sel;
            sel_oh      <= win_oh;
            grant       <= win_oh;
            param_id    <= 1'b1;
            param_data  <= mask_sel[7:0];
            busy        <= 1'b1;
          end
        end
        SEND0: begin
          state      <= SEND1;
          param_id   <= 1'b0;
          param_data <= {code_sh[4:0], mask_hi_sh};
        end
        SEND1: begin
          state      <= SEND2;
          param_data <= {sjw_sh, code_sh[10:5]};
        end
        SEND2: begin
          state      <= GAP;
          param_data <= '0;
          grant      <= '0;
          done       <= sel_oh;
          gap_cnt    <= GW'(GAP_CYCLES - 1);
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_param_loader.sv
// Scoreboard bench for can_param_loader: directed loads push expected byte
// sequences; a monitor pops one entry per param_id strobe and checks it.
module tb_can_param_loader;

  localparam int NUM_REQ    = 2;
  localparam int GAP_CYCLES = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [11*NUM_REQ-1:0] mask_in;
  logic [11*NUM_REQ-1:0] code_in;
  logic [2*NUM_REQ-1:0]  sjw_in;
  logic                  param_id;
  logic [7:0]            param_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;

  can_param_loader #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset(reset), .req(req), .mask_in(mask_in), .code_in(code_in),
    .sjw_in(sjw_in), .param_id(param_id), .param_data(param_data),
    .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] g;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_cyc = 0;
  bit   pid_seen = 0;
  bit   prev_en = 0;
  bit   spacing_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req_v, cyc);
    end
  endtask

  task automatic push(input logic [NUM_REQ-1:0] g, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    e.g = g; e.b0 = b0; e.b1 = b1; e.b2 = b2;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input int idx, input logic [10:0] m, input logic [10:0] c,
                        input logic [1:0] s);
    mask_in[11*idx +: 11] = m;
    code_in[11*idx +: 11] = c;
    sjw_in[2*idx +: 2]    = s;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 60);
    chk("done_timeout", {31'b0, (done != '0)}, 32'd1);
  endtask

  task automatic wait_pid();
    int n = 0;
    do begin @(negedge clk); n++; end while (!param_id && n < 60);
    chk("pid_timeout", {31'b0, param_id}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_param_id"}, param_id, 0);
    chk({tag, "_param_data"}, param_data, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: each param_id strobe must match the next queued load.
  initial forever begin
    @(negedge clk);
    if (!reset && param_id) begin
      if (pid_seen && spacing_en && prev_en)
        chk("pid_spacing", cyc - prev_cyc, 4 + GAP_CYCLES);
      prev_cyc = cyc;
      prev_en  = spacing_en;
      pid_seen = 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_load", {31'b0, param_id}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("byte0", param_data, mon_e.b0);
        chk("grant0", grant, mon_e.g);
        chk("busy0", busy, 1);
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          if (reset) break;
          if (k == 1) begin
            chk("byte1", param_data, mon_e.b1);
            chk("grant1", grant, mon_e.g);
            chk("pid1", param_id, 0);
          end else if (k == 2) begin
            chk("byte2", param_data, mon_e.b2);
            chk("grant2", grant, mon_e.g);
          end else begin
            chk("done", done, mon_e.g);
            chk("gap_grant", grant, 0);
            chk("gap_data", param_data, 0);
            chk("gap_busy", busy, 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; mask_in = '0; code_in = '0; sjw_in = '0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // Single load on requester 0
    @(negedge clk);
    set_in(0, 11'h5A3, 11'h2C7, 2'd2);
    push(2'b01, 8'hA3, 8'h3D, 8'h96);
    req = 2'b01;
    wait_done();
    req = 2'b00;
    repeat (GAP_CYCLES - 1) begin @(negedge clk); chk("gap_busy_hold", busy, 1); end
    @(negedge clk); chk("busy_fall", busy, 0);

    // Round-robin from fresh reset, both held
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    set_in(1, 11'h123, 11'h456, 2'd1);
    spacing_en = 1;
    push(2'b01, 8'hA3, 8'h3D, 8'h96);
    push(2'b10, 8'h23, 8'hB1, 8'h62);
    push(2'b01, 8'hA3, 8'h3D, 8'h96);
    push(2'b10, 8'h23, 8'hB1, 8'h62);
    req = 2'b11;
    repeat (4) wait_done();
    req = 2'b00;
    spacing_en = 0;
    repeat (6) @(negedge clk);

    // Requester 1 inputs change while its set is on the wire
    set_in(1, 11'h0C8, 11'h1F5, 2'd3);
    push(2'b10, 8'hC8, 8'hA8, 8'hCF);
    req = 2'b10;
    wait_pid();
    set_in(1, 11'h7FF, 11'h7FF, 2'd0);
    wait_done();
    req = 2'b00;
    repeat (6) @(negedge clk);

    // Requester 0 drops req during SEND0
    set_in(0, 11'h0F0, 11'h3AB, 2'd0);
    push(2'b01, 8'hF0, 8'h58, 8'h1D);
    req = 2'b01;
    wait_pid();
    req = 2'b00;
    wait_done();
    repeat (12) @(negedge clk);
    chk("drop_idle_busy", busy, 0);

    // Reset during SEND1, then requester 1 alone
    push(2'b01, 8'hF0, 8'h58, 8'h1D);
    req = 2'b01;
    wait_pid();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    req = 2'b10;
    set_in(1, 11'h123, 11'h456, 2'd1);
    push(2'b10, 8'h23, 8'hB1, 8'h62);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_done();
    req = 2'b00;
    repeat (6) @(negedge clk);

    // Extremes back-to-back on requester 0
    set_in(0, 11'h7FF, 11'h000, 2'd3);
    spacing_en = 1;
    push(2'b01, 8'hFF, 8'h07, 8'hC0);
    push(2'b01, 8'h00, 8'h00, 8'h00);
    req = 2'b01;
    wait_done();
    set_in(0, 11'h000, 11'h000, 2'd0);
    wait_done();
    req = 2'b00;
    spacing_en = 0;

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
